// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (rise to rise) of an asynchronous PWM input.
// Optional glitch filter on the synchronized input is built when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_capture #(
  parameter int COUNTER_WIDTH = 16,
  parameter int FILTER_LENGTH = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     pwm_input,
  output logic [COUNTER_WIDTH-1:0] high_count,
  output logic [COUNTER_WIDTH-1:0] period_count,
  output logic                     duty_valid,
  output logic                     timeout
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEAS_HIGH = 2'd1,
    S_MEAS_LOW  = 2'd2
  } state_t;

  if (FILTER_LENGTH < 2) begin : g_filter_length_check
    $error("pwm_capture: FILTER_LENGTH must be at least 2");
  end

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_prev_pin;
  logic                     w_pin;
  logic                     w_rise;
  logic                     w_fall;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [COUNTER_WIDTH-1:0] r_period_cnt;
  logic [COUNTER_WIDTH-1:0] r_high_cnt;
  logic [COUNTER_WIDTH-1:0] r_high_count;
  logic [COUNTER_WIDTH-1:0] r_period_count;
  logic                     r_duty_valid;
  logic                     r_timeout;

  logic                     w_sat;
  logic                     w_clr;
  logic                     w_start;
  logic                     w_inc_period;
  logic                     w_inc_high;
  logic                     w_latch;
  logic                     w_set_timeout;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_input;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LENGTH + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LENGTH - 1);

  logic [FLT_W-1:0] r_flt_cnt;
  logic             r_flt_pin;

  // Level only moves after FILTER_LENGTH consecutive samples disagree with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flt_cnt <= '0;
      r_flt_pin <= 1'b0;
    end else if (r_sync2 != r_flt_pin) begin
      if (r_flt_cnt == FLT_LAST) begin
        r_flt_pin <= r_sync2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end else begin
      r_flt_cnt <= '0;
    end
  end

  assign w_pin = r_flt_pin;
`else
  assign w_pin = r_sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_pin <= 1'b0;
    end else begin
      r_prev_pin <= w_pin;
    end
  end

  assign w_rise = w_pin & ~r_prev_pin;
  assign w_fall = ~w_pin & r_prev_pin;
  assign w_sat  = (r_period_cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: enable low wins, then counter saturation, then edges
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) w_state_nxt = S_MEAS_HIGH;
        end
        S_MEAS_HIGH: begin
          if (w_sat)       w_state_nxt = S_IDLE;
          else if (w_fall) w_state_nxt = S_MEAS_LOW;
        end
        S_MEAS_LOW: begin
          if (w_sat)       w_state_nxt = S_IDLE;
          else if (w_rise) w_state_nxt = S_MEAS_HIGH;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_clr         = 1'b0;
    w_start       = 1'b0;
    w_inc_period  = 1'b0;
    w_inc_high    = 1'b0;
    w_latch       = 1'b0;
    w_set_timeout = 1'b0;
    if (!enable) begin
      w_clr = 1'b0 | 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_start = w_rise;
        end
        S_MEAS_HIGH: begin
          if (w_sat) begin
            w_clr         = 1'b1;
            w_set_timeout = 1'b1;
          end else if (w_fall) begin
            w_inc_period = 1'b1;
          end else begin
            w_inc_period = 1'b1;
            w_inc_high   = 1'b1;
          end
        end
        S_MEAS_LOW: begin
          if (w_sat) begin
            w_clr         = 1'b1;
            w_set_timeout = 1'b1;
          end else if (w_rise) begin
            w_latch = 1'b1;
            w_start = 1'b1;
          end else begin
            w_inc_period = 1'b1;
          end
        end
        default: w_clr = 1'b1;
      endcase
    end
  end

  // The completing rise reports the pre-update counts and reloads 1/1 for the new period
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_period_cnt   <= CNT_ZERO;
      r_high_cnt     <= CNT_ZERO;
      r_high_count   <= CNT_ZERO;
      r_period_count <= CNT_ZERO;
      r_duty_valid   <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_duty_valid <= w_latch;
      if (w_clr) begin
        r_period_cnt <= CNT_ZERO;
        r_high_cnt   <= CNT_ZERO;
      end else if (w_start) begin
        r_period_cnt <= CNT_ONE;
        r_high_cnt   <= CNT_ONE;
      end else begin
        if (w_inc_period) r_period_cnt <= r_period_cnt + CNT_ONE;
        if (w_inc_high)   r_high_cnt   <= r_high_cnt + CNT_ONE;
      end
      if (w_latch) begin
        r_high_count   <= r_high_cnt;
        r_period_count <= r_period_cnt;
        r_timeout      <= 1'b0;
      end else if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign high_count   = r_high_count;
  assign period_count = r_period_count;
  assign duty_valid   = r_duty_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: a 16-bit and an 8-bit instance driven by directed PWM sequences,
// with expected measurements queued at stimulus time and compared on each duty_valid strobe.
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16 = 1'b1, en16 = 1'b0, pwm16 = 1'b0;
  logic [15:0] hc16, pc16;
  logic        dv16, to16;

  logic        rst8 = 1'b1, en8 = 1'b0, pwm8 = 1'b0;
  logic [7:0]  hc8, pc8;
  logic        dv8, to8;

  pwm_capture #(.COUNTER_WIDTH(16), .FILTER_LENGTH(3)) u_dut16 (
    .clock(clk), .reset(rst16), .enable(en16), .pwm_input(pwm16),
    .high_count(hc16), .period_count(pc16), .duty_valid(dv16), .timeout(to16)
  );

  pwm_capture #(.COUNTER_WIDTH(8), .FILTER_LENGTH(3)) u_dut8 (
    .clock(clk), .reset(rst8), .enable(en8), .pwm_input(pwm8),
    .high_count(hc8), .period_count(pc8), .duty_valid(dv8), .timeout(to8)
  );

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT_DELAY = 3;
`else
  localparam int FLT_DELAY = 0;
`endif

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] p;
  } exp_t;

  exp_t        q16[$];
  exp_t        q8[$];
  exp_t        e16, e8;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_h16 = '0, last_p16 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push16(input int h, input int p);
    exp_t e;
    e.h = 16'(h);
    e.p = 16'(p);
    q16.push_back(e);
  endtask

  task automatic drive16(input int h, input int l);
    pwm16 = 1'b1;
    repeat (h) tick();
    pwm16 = 1'b0;
    repeat (l) tick();
  endtask

  task automatic cyc16(input int h, input int l);
    push16(h, h + l);
    drive16(h, l);
  endtask

  // Closing rise completes the last queued period, then disabling drops back to IDLE
  task automatic close16();
    pwm16 = 1'b1;
    repeat (10) tick();
    en16 = 1'b0;
    pwm16 = 1'b0;
    repeat (6) tick();
    check("q16_drained", q16.size(), 0);
    en16 = 1'b1;
    repeat (2) tick();
  endtask

  always @(negedge clk) begin
    if (dv16 === 1'b1) begin
      check("dv16_expected", (q16.size() != 0), 1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        check("high16", hc16, e16.h);
        check("period16", pc16, e16.p);
        last_h16 = e16.h;
        last_p16 = e16.p;
      end
    end
    if (dv8 === 1'b1) begin
      check("dv8_expected", (q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("high8", {8'd0, hc8}, e8.h);
        check("period8", {8'd0, pc8}, e8.p);
      end
    end
  end

  initial begin
    int n;
    int h;
    int l;
    exp_t e;

    repeat (3) tick();
    check("rst_high16", hc16, 0);
    check("rst_period16", pc16, 0);
    check("rst_valid16", dv16, 0);
    check("rst_timeout16", to16, 0);
    check("rst_timeout8", to8, 0);
    rst16 = 1'b0;
    rst8  = 1'b0;
    en16  = 1'b1;
    en8   = 1'b1;
    repeat (3) tick();

    // 40 high / 60 low
    for (int i = 0; i < 5; i++) cyc16(40, 60);
    close16();
    check("t1_high", hc16, 40);
    check("t1_period", pc16, 100);

    // 8-bit free-running generator, high while count <= 128
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 256; c++) begin
        if (c == 0) push16(129, 256);
        pwm16 = (c <= 128);
        tick();
      end
    end
    close16();
    check("t2_high", hc16, 129);
    check("t2_period", pc16, 256);

    // Minimum-width pulses and random shapes
    cyc16(1, 1);
    cyc16(1, 5);
    cyc16(7, 1);
    cyc16(3, 3);
    for (int i = 0; i < 6; i++) begin
      h = int'($urandom_range(1, 30));
      l = int'($urandom_range(1, 30));
      cyc16(h, l);
    end
    close16();
    check("t_rand_high_hold", hc16, last_h16);

    // Disable mid-high: no strobe, results and timeout hold
    pwm16 = 1'b1;
    repeat (20) tick();
    en16 = 1'b0;
    repeat (5) tick();
    check("t4_valid_off", dv16, 0);
    check("t4_high_hold", hc16, last_h16);
    check("t4_period_hold", pc16, last_p16);
    check("t4_timeout_hold", to16, 0);
    en16 = 1'b1;
    repeat (10) tick();
    pwm16 = 1'b0;
    repeat (10) tick();
    cyc16(15, 25);
    close16();
    check("t4_high", hc16, 15);
    check("t4_period", pc16, 40);

    // Asynchronous reset mid-period
    pwm16 = 1'b1;
    repeat (20) tick();
    rst16 = 1'b1;
    #1;
    check("t5_high_rst", hc16, 0);
    check("t5_period_rst", pc16, 0);
    check("t5_valid_rst", dv16, 0);
    check("t5_timeout_rst", to16, 0);
    pwm16 = 1'b0;
    repeat (2) tick();
    rst16 = 1'b0;
    repeat (3) tick();
    cyc16(12, 8);
    close16();
    check("t5_high", hc16, 12);
    check("t5_period", pc16, 20);

    // 2-clock low glitch inside a 50-clock high
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    push16(50, 100);
    drive16(20, 2);
    drive16(28, 50);
    close16();
    check("t6_high", hc16, 50);
`else
    push16(20, 22);
    drive16(20, 2);
    push16(28, 78);
    drive16(28, 50);
    close16();
    check("t6_high", hc16, 28);
`endif

    // 8-bit instance: input stuck high saturates the period counter
    pwm8 = 1'b1;
    n = 0;
    while (to8 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("t3_timeout_latency", n, 258 + FLT_DELAY);
    check("t3_high_kept", {8'd0, hc8}, 0);
    check("t3_period_kept", {8'd0, pc8}, 0);
    pwm8 = 1'b0;
    repeat (10) tick();
    check("t3_timeout_sticky", to8, 1);
    e.h = 16'd10;
    e.p = 16'd20;
    q8.push_back(e);
    pwm8 = 1'b1;
    repeat (10) tick();
    pwm8 = 1'b0;
    repeat (10) tick();
    pwm8 = 1'b1;
    check("t3_timeout_before_rise", to8, 1);
    repeat (10) tick();
    check("t3_timeout_cleared", to8, 0);
    check("t3_high", {8'd0, hc8}, 10);
    check("t3_period", {8'd0, pc8}, 20);

    // 0% duty after a measurement also times out
    pwm8 = 1'b0;
    n = 0;
    while (to8 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("t3_low_timeout", to8, 1);
    check("t3_low_high_kept", {8'd0, hc8}, 10);

    repeat (5) tick();
    check("q16_empty_end", q16.size(), 0);
    check("q8_empty_end", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
